// File: rtl/pe_array_seq_if.sv
// Command, C-preload, array-edge control and writeback signals of the PE tile sequencer.
// With PE_SEQ_PERF_EN defined the bundle also carries the two performance counters.
interface pe_array_seq_if #(
  parameter int KW = 16
);
  logic          start;
  logic [KW-1:0] k_len;
  logic [1:0]    datatype;
  logic          c_valid;
  logic          c_ready;
  logic          we;
  logic          en_inject;
  logic          cm_inject;
  logic          wben;
  logic          out_ready;
  logic          out_valid;
  logic          busy;
  logic          done;
`ifdef PE_SEQ_PERF_EN
  logic [31:0]   perf_busy_cyc;
  logic [31:0]   perf_stall_cyc;

  modport master (
    output start, k_len, datatype, c_valid, out_ready,
    input  c_ready, we, en_inject, cm_inject, wben, out_valid, busy, done,
    input  perf_busy_cyc, perf_stall_cyc
  );
  modport slave (
    input  start, k_len, datatype, c_valid, out_ready,
    output c_ready, we, en_inject, cm_inject, wben, out_valid, busy, done,
    output perf_busy_cyc, perf_stall_cyc
  );
`else
  modport master (
    output start, k_len, datatype, c_valid, out_ready,
    input  c_ready, we, en_inject, cm_inject, wben, out_valid, busy, done
  );
  modport slave (
    input  start, k_len, datatype, c_valid, out_ready,
    output c_ready, we, en_inject, cm_inject, wben, out_valid, busy, done
  );
`endif
endinterface

// File: rtl/pe_array_seq.sv
// Tile sequencer for the NxN systolic PE array: C preload, K stream, drain, writeback.
// Optional macro PE_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module pe_array_seq #(
  parameter int N       = 4,
  parameter int REGS    = 4,
  parameter int MAC_LAT = 2,
  parameter int KW      = 16
) (
  input logic          clk,
  input logic          rst,
  pe_array_seq_if.slave bus
);

  localparam int BEAT_W    = $clog2(REGS) + 1;
  // Skew through the array in both dimensions plus the MAC pipe and one settle cycle.
  localparam int DRAIN_LEN = 2 * (N - 1) + MAC_LAT + 1;
  localparam int DRAIN_W   = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COMP  = 3'd2,
    CMB   = 3'd3,
    DRAIN = 3'd4,
    WB    = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [KW-1:0]       k_cnt_r;
  logic [DRAIN_W-1:0]  drain_cnt_r;
  logic [KW-1:0]       k_len_r;
  logic [1:0]          datatype_r;
  logic                c_ready_r;
  logic                en_inject_r;
  logic                cm_inject_r;
  logic                wben_r;
  logic                busy_r;
  logic                done_r;

  logic                beat_last_s;
  logic                k_last_s;
  logic                drain_last_s;

  assign beat_last_s  = (beat_cnt_r == BEAT_W'(REGS - 1));
  assign k_last_s     = (k_cnt_r == (k_len_r - {{(KW-1){1'b0}}, 1'b1}));
  assign drain_last_s = (drain_cnt_r == DRAIN_W'(DRAIN_LEN - 1));

  // Next-state decode for the tile phases.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = LOAD;
        else           state_nxt_s = IDLE;
      end
      LOAD: begin
        if (bus.c_valid && beat_last_s) begin
          if (k_len_r == {KW{1'b0}}) state_nxt_s = DRAIN;
          else                       state_nxt_s = COMP;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      COMP: begin
        if (k_last_s) begin
          if (datatype_r == 2'd3) state_nxt_s = CMB;
          else                    state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = COMP;
        end
      end
      CMB:   state_nxt_s = DRAIN;
      DRAIN: begin
        if (drain_last_s) state_nxt_s = WB;
        else              state_nxt_s = DRAIN;
      end
      WB: begin
        if (bus.out_ready && beat_last_s) state_nxt_s = DONE;
        else                              state_nxt_s = WB;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, phase counters and output flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_cnt_r  <= {BEAT_W{1'b0}};
      k_cnt_r     <= {KW{1'b0}};
      drain_cnt_r <= {DRAIN_W{1'b0}};
      k_len_r     <= {KW{1'b0}};
      datatype_r  <= 2'd0;
      c_ready_r   <= 1'b0;
      en_inject_r <= 1'b0;
      cm_inject_r <= 1'b0;
      wben_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      c_ready_r   <= (state_nxt_s == LOAD);
      en_inject_r <= (state_nxt_s == COMP);
      cm_inject_r <= (state_nxt_s == CMB);
      wben_r      <= (state_nxt_s == WB);
      busy_r      <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
      done_r      <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            k_len_r     <= bus.k_len;
            datatype_r  <= bus.datatype;
            beat_cnt_r  <= {BEAT_W{1'b0}};
            k_cnt_r     <= {KW{1'b0}};
            drain_cnt_r <= {DRAIN_W{1'b0}};
          end
        end
        LOAD: begin
          if (bus.c_valid) beat_cnt_r <= beat_cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        end
        COMP: begin
          if (k_last_s) k_cnt_r <= {KW{1'b0}};
          else          k_cnt_r <= k_cnt_r + {{(KW-1){1'b0}}, 1'b1};
        end
        DRAIN: begin
          if (drain_last_s) begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
            beat_cnt_r  <= {BEAT_W{1'b0}};
          end else begin
            drain_cnt_r <= drain_cnt_r + {{(DRAIN_W-1){1'b0}}, 1'b1};
          end
        end
        WB: begin
          if (bus.out_ready) beat_cnt_r <= beat_cnt_r + {{(BEAT_W-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.c_ready   = c_ready_r;
  assign bus.we        = c_ready_r & bus.c_valid;
  assign bus.en_inject = en_inject_r;
  assign bus.cm_inject = cm_inject_r;
  assign bus.wben      = wben_r;
  assign bus.out_valid = wben_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_busy_r;
  logic [31:0] perf_stall_r;
  logic        stall_s;

  assign stall_s = ((state_r == LOAD) && !bus.c_valid) ||
                   ((state_r == WB) && !bus.out_ready);

  // Saturating busy/stall counters, restarted by each accepted tile command.
  always_ff @(posedge clk) begin
    if (rst || ((state_r == IDLE) && bus.start)) begin
      perf_busy_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (busy_r && (perf_busy_r != 32'hFFFF_FFFF)) perf_busy_r <= perf_busy_r + 32'd1;
      else                                          perf_busy_r <= perf_busy_r;
      if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) perf_stall_r <= perf_stall_r + 32'd1;
      else                                            perf_stall_r <= perf_stall_r;
    end
  end

  assign bus.perf_busy_cyc  = perf_busy_r;
  assign bus.perf_stall_cyc = perf_stall_r;
`endif

endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq: cycle-accurate phase windows, INT4 combine, k_len=0,
// writeback backpressure, mid-tile reset and ignored start.
module tb_pe_array_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pe_array_seq_if #(.KW(16)) bus ();

  pe_array_seq #(.N(4), .REGS(4), .MAC_LAT(2), .KW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {c_ready, we, en_inject, cm_inject, wben, out_valid, busy, done}
  function automatic logic [7:0] outs();
    return {bus.c_ready, bus.we, bus.en_inject, bus.cm_inject,
            bus.wben, bus.out_valid, bus.busy, bus.done};
  endfunction

  // One unstalled tile started in cycle 0; done expected at hand-computed cycle exp_done.
  task automatic run_tile(input int k, input logic [1:0] dt, input int exp_done,
                          input int pulse_at, input string name);
    int ce, cb, ds, de, ws, we_end, dones;
    logic [7:0] e;
    ce     = 4 + k;
    cb     = (dt == 2'd3) ? ce + 1 : -1;
    ds     = ce + 1 + ((dt == 2'd3) ? 1 : 0);
    de     = ds + 8;
    ws     = de + 1;
    we_end = ws + 3;
    dones  = 0;
    bus.start = 1'b1; bus.k_len = 16'(k); bus.datatype = dt;
    bus.c_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 1; c <= exp_done + 2; c++) begin
      step();
      bus.start = (c == pulse_at) ? 1'b1 : 1'b0;
      e = 8'd0;
      if (c >= 1 && c <= 4)       e = e | 8'b1100_0010;
      if (c >= 5 && c <= ce)      e = e | 8'b0010_0010;
      if (c == cb)                e = e | 8'b0001_0010;
      if (c >= ds && c <= de)     e = e | 8'b0000_0010;
      if (c >= ws && c <= we_end) e = e | 8'b0000_1110;
      if (c == exp_done)          e = e | 8'b0000_0001;
      chk($sformatf("%s c%0d", name, c), {24'd0, outs()}, {24'd0, e});
      if (bus.done) dones++;
    end
    chk({name, " done_count"}, 32'(dones), 32'd1);
  endtask

  initial begin
    logic [6:0] pat;
    int         fires;
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.k_len = 16'd0; bus.datatype = 2'd0;
    bus.c_valid = 1'b0; bus.out_ready = 1'b0;
    step(); step();
    chk("reset outs", {24'd0, outs()}, 32'd0);
`ifdef PE_SEQ_PERF_EN
    chk("reset perf_busy", bus.perf_busy_cyc, 32'd0);
    chk("reset perf_stall", bus.perf_stall_cyc, 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("idle outs", {24'd0, outs()}, 32'd0);

    // FP32 k=8: LOAD 1-4, COMP 5-12, DRAIN 13-21, WB 22-25, done 26.
    run_tile(8, 2'd0, 26, -1, "fp32_k8");
    // INT4 k=3: combine at 8, done at 22; INT8 k=3 done at 21.
    run_tile(3, 2'd3, 22, -1, "int4_k3");
    run_tile(3, 2'd2, 21, -1, "int8_k3");
    // k=0 FP16: 1+4+9+4+1 = 19 cycles start..done inclusive, done pulse at index 18.
    run_tile(0, 2'd1, 18, -1, "fp16_k0");
    // start pulsed in DRAIN (cycle 15) is ignored.
    run_tile(8, 2'd0, 26, 15, "start_in_drain");

    // WB backpressure: k=1, WB starts cycle 15, out_ready 1,0,0,1,1,0,1 -> done at 22.
    pat = 7'b1011001;  // bit i = out_ready in WB cycle 15+i
    fires = 0;
    bus.start = 1'b1; bus.k_len = 16'd1; bus.datatype = 2'd0;
    bus.c_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      step();
      bus.start = 1'b0;
      if (c >= 15 && c <= 21) bus.out_ready = pat[c - 15];
      else                    bus.out_ready = 1'b1;
      if (c >= 15 && c <= 21) begin
        chk($sformatf("bp wben c%0d", c), {31'd0, bus.wben}, 32'd1);
        chk($sformatf("bp out_valid c%0d", c), {31'd0, bus.out_valid}, 32'd1);
        if (bus.out_ready) fires++;
      end
      chk($sformatf("bp done c%0d", c), {31'd0, bus.done}, (c == 22) ? 32'd1 : 32'd0);
      if (c == 22) begin
`ifdef PE_SEQ_PERF_EN
        chk("bp perf_stall", bus.perf_stall_cyc, 32'd3);
        chk("bp perf_busy", bus.perf_busy_cyc, 32'd21);
`endif
      end
    end
    chk("bp fires", 32'(fires), 32'd4);

    // Reset asserted during COMP cycle 7: outputs clear at cycle 8, no done afterwards.
    bus.start = 1'b1; bus.k_len = 16'd8; bus.datatype = 2'd0;
    bus.c_valid = 1'b1; bus.out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      bus.start = 1'b0;
    end
    chk("rst pre en_inject", {31'd0, bus.en_inject}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst outs", {24'd0, outs()}, 32'd0);
    rst = 1'b0;
    for (int c = 9; c <= 30; c++) begin
      step();
      chk($sformatf("post_rst c%0d", c), {24'd0, outs()}, 32'd0);
    end
    run_tile(8, 2'd0, 26, -1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
